// File: rtl/pio_edge_irq.sv
// Avalon-MM GPIO: synchronised and debounced inputs, sticky per-channel edge capture
// with a maskable level interrupt, and an output register with atomic set/clear.
module pio_edge_irq #(
  parameter int          IN_WIDTH        = 4,
  parameter int          OUT_WIDTH       = 18,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          EDGE_TYPE       = 0,
  parameter logic [31:0] OUT_RESET       = 32'h0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  input  logic [IN_WIDTH-1:0]  in_export,
  output logic [OUT_WIDTH-1:0] out_export,
  output logic                 irq
);

  localparam logic [2:0] A_DATA_IN  = 3'd0;
  localparam logic [2:0] A_DATA_OUT = 3'd1;
  localparam logic [2:0] A_MASK     = 3'd2;
  localparam logic [2:0] A_EDGE     = 3'd3;
  localparam logic [2:0] A_OUT_SET  = 3'd4;
  localparam logic [2:0] A_OUT_CLR  = 3'd5;
  localparam logic [2:0] A_PARAMS   = 3'd6;

  localparam logic [31:0] PARAMS_WORD = {14'd0, 2'(EDGE_TYPE), 2'd0, 6'(OUT_WIDTH),
                                         2'd0, 6'(IN_WIDTH)};

  logic [IN_WIDTH-1:0]  sync1_q, sync2_q, deb, deb_prev_q;
  logic [IN_WIDTH-1:0]  rise, fall, edge_sel, w1c;
  logic [IN_WIDTH-1:0]  edge_q, edge_d, mask_q, mask_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 irq_q;
  logic                 unused_wdata;

  assign unused_wdata = ^avs_writedata;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_export;
      sync2_q <= sync1_q;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign deb = sync2_q;
  end else begin : g_deb
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // the increment that would reach DEBOUNCE_CYCLES commits the new value instead
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]            deb_q, deb_d;

    always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        cnt_q <= '0;
        deb_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign deb = deb_q;
  end

  assign rise = deb & ~deb_prev_q;
  assign fall = ~deb & deb_prev_q;

  always_comb begin
    if (EDGE_TYPE == 0)      edge_sel = rise;
    else if (EDGE_TYPE == 1) edge_sel = fall;
    else                     edge_sel = rise | fall;
  end

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    w1c    = '0;
    if (avs_write) begin
      case (avs_address)
        A_DATA_OUT: out_d  = avs_writedata[OUT_WIDTH-1:0];
        A_OUT_SET:  out_d  = out_q | avs_writedata[OUT_WIDTH-1:0];
        A_OUT_CLR:  out_d  = out_q & ~avs_writedata[OUT_WIDTH-1:0];
        A_MASK:     mask_d = avs_writedata[IN_WIDTH-1:0];
        A_EDGE:     w1c    = avs_writedata[IN_WIDTH-1:0];
        default:    ;
      endcase
    end
    // a new edge overrides a same-cycle clear of that bit
    edge_d = (edge_q & ~w1c) | edge_sel;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        A_DATA_IN:  rdata_d = 32'(deb);
        A_DATA_OUT: rdata_d = 32'(out_q);
        A_MASK:     rdata_d = 32'(mask_q);
        A_EDGE:     rdata_d = 32'(edge_q);
        A_PARAMS:   rdata_d = PARAMS_WORD;
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      deb_prev_q <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      out_q      <= OUT_RESET[OUT_WIDTH-1:0];
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      deb_prev_q <= deb;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      out_q      <= out_d;
      rdata_q    <= rdata_d;
      irq_q      <= |(edge_q & mask_q);
    end
  end

  assign avs_readdata = rdata_q;
  assign out_export   = out_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_pio_edge_irq.sv
// Self-checking bench for pio_edge_irq: register-access vector table, directed
// debounce/edge/irq sequences, and a randomized run against a behavioural model.
module tb_pio_edge_irq;

  logic        clk_clk;
  logic        reset_reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [3:0]  in_export;
  logic [17:0] out_export;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  pio_edge_irq #(
    .IN_WIDTH       (4),
    .OUT_WIDTH      (18),
    .DEBOUNCE_CYCLES(16),
    .EDGE_TYPE      (0),
    .OUT_RESET      (32'h0002_AAAA)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .in_export    (in_export),
    .out_export   (out_export),
    .irq          (irq)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] d);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
    @(negedge clk_clk);
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset_reset = 1'b1;
    cyc(n);
    reset_reset = 1'b0;
  endtask

  // Polls DATA_IN[0] every cycle; readdata lags the debounced value by one cycle.
  task automatic measure_deb(input string name, input int exp_lat);
    int  n;
    bit  seen;
    n = 0; seen = 0;
    avs_address = 3'd0; avs_read = 1'b1;
    while (!seen && n < 60) begin
      @(negedge clk_clk);
      n++;
      if (avs_readdata[0]) seen = 1;
    end
    avs_read = 1'b0;
    check(name, seen ? 32'(n - 1) : 32'd999, 32'(exp_lat));
  endtask

  // Behavioural model: a channel's debounced value flips once its synchronised
  // input has disagreed with it for 16 consecutive cycles.
  logic [3:0]  inhist[$];
  logic [3:0]  m_deb, m_prev, m_edge, m_mask;
  logic        m_irq;
  logic [31:0] m_rdata;
  logic [17:0] m_out;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {28'd0, m_deb};
      3'd1:    return {14'd0, m_out};
      3'd2:    return {28'd0, m_mask};
      3'd3:    return {28'd0, m_edge};
      3'd6:    return 32'h0000_1204;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_deb = '0; m_prev = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0;
    m_rdata = '0; m_out = 18'h2AAAA;
    inhist.delete();
    repeat (18) inhist.push_back(4'h0);
  endtask

  task automatic model_step(input logic rst, input logic [3:0] din, input logic rd,
                            input logic wr, input logic [2:0] a, input logic [31:0] d);
    logic [3:0]  n_deb, rise, clr;
    logic [17:0] n_out;
    logic        all_other;
    int          sz;
    if (rst) begin
      model_reset();
      return;
    end
    inhist.push_back(din);
    if (inhist.size() > 40) void'(inhist.pop_front());
    sz = inhist.size();
    n_deb = m_deb;
    for (int i = 0; i < 4; i++) begin
      all_other = 1'b1;
      for (int j = sz - 18; j <= sz - 3; j++)
        if (inhist[j][i] == m_deb[i]) all_other = 1'b0;
      if (all_other) n_deb[i] = ~m_deb[i];
    end
    rise  = m_deb & ~m_prev;
    clr   = (wr && a == 3'd3) ? d[3:0] : 4'h0;
    n_out = m_out;
    if (wr && a == 3'd1) n_out = d[17:0];
    if (wr && a == 3'd4) n_out = m_out | d[17:0];
    if (wr && a == 3'd5) n_out = m_out & ~d[17:0];
    if (rd) m_rdata = m_read(a);
    m_irq  = |(m_edge & m_mask);
    m_edge = (m_edge & ~clr) | rise;
    if (wr && a == 3'd2) m_mask = d[3:0];
    m_prev = m_deb;
    m_deb  = n_deb;
    m_out  = n_out;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [17:0] exp_out;
  } vec_t;

  vec_t vecs[21];

  initial begin
    bit glitch;
    int hold[4];

    vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,        32'h0,        18'h2AAAA};
    vecs[1]  = '{1'b1, 1'b0, 3'd2, 32'h0,        32'h0,        18'h2AAAA};
    vecs[2]  = '{1'b1, 1'b0, 3'd3, 32'h0,        32'h0,        18'h2AAAA};
    vecs[3]  = '{1'b1, 1'b0, 3'd6, 32'h0,        32'h0000_1204, 18'h2AAAA};
    vecs[4]  = '{1'b1, 1'b0, 3'd7, 32'h0,        32'h0,        18'h2AAAA};
    vecs[5]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0F0F, 32'h0,       18'h00F0F};
    vecs[6]  = '{1'b0, 1'b1, 3'd4, 32'h0003_0000, 32'h0,       18'h30F0F};
    vecs[7]  = '{1'b0, 1'b1, 3'd5, 32'h0000_000F, 32'h0,       18'h30F00};
    vecs[8]  = '{1'b1, 1'b0, 3'd1, 32'h0,        32'h0003_0F00, 18'h30F00};
    vecs[9]  = '{1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0,       18'h30F00};
    vecs[10] = '{1'b1, 1'b0, 3'd0, 32'h0,        32'h0,        18'h30F00};
    vecs[11] = '{1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0,       18'h30F00};
    vecs[12] = '{1'b0, 1'b1, 3'd6, 32'h0,        32'h0,        18'h30F00};
    vecs[13] = '{1'b1, 1'b1, 3'd2, 32'h0000_00FF, 32'h0,       18'h30F00};
    vecs[14] = '{1'b1, 1'b0, 3'd2, 32'h0,        32'h0000_000F, 18'h30F00};
    vecs[15] = '{1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0003_0F00, 18'h3FFFF};
    vecs[16] = '{1'b1, 1'b0, 3'd1, 32'h0,        32'h0003_FFFF, 18'h3FFFF};
    vecs[17] = '{1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0,       18'h00000};
    vecs[18] = '{1'b0, 1'b1, 3'd4, 32'h0001_2345, 32'h0,       18'h12345};
    vecs[19] = '{1'b1, 1'b0, 3'd6, 32'h0,        32'h0000_1204, 18'h12345};
    vecs[20] = '{1'b0, 1'b1, 3'd2, 32'h0,        32'h0,        18'h12345};

    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    in_export = '0;

    // reset state
    do_reset(2);
    check("reset out_export", {14'd0, out_export}, 32'h0002_AAAA);
    check("reset irq", {31'd0, irq}, 32'd0);
    check("reset readdata", avs_readdata, 32'd0);

    for (int k = 0; k < 21; k++) begin
      bus(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata);
      check($sformatf("vec%0d out_export", k), {14'd0, out_export}, {14'd0, vecs[k].exp_out});
      if (vecs[k].rd)
        check($sformatf("vec%0d readdata", k), avs_readdata, vecs[k].exp_rd);
    end

    // glitch shorter than the debounce window, then a held rise
    glitch = 0;
    avs_address = 3'd0; avs_read = 1'b1;
    in_export = 4'h1;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) in_export = 4'h0;
      @(negedge clk_clk);
      if (avs_readdata[0]) glitch = 1;
    end
    avs_read = 1'b0;
    check("glitch rejected", {31'd0, glitch}, 32'd0);
    in_export = 4'h1;
    measure_deb("debounce latency", 18);

    // edge capture and irq timing
    in_export = 4'h0;
    do_reset(2);
    bus(1'b0, 1'b1, 3'd2, 32'h1);
    in_export = 4'h1;
    cyc(19);
    check("irq before edge", {31'd0, irq}, 32'd0);
    cyc(1);
    check("irq after edge", {31'd0, irq}, 32'd1);
    bus(1'b1, 1'b0, 3'd3, 32'h0);
    check("edge bit0", avs_readdata, 32'h1);
    in_export = 4'h3;
    cyc(25);
    check("irq unmasked edge", {31'd0, irq}, 32'd1);
    bus(1'b1, 1'b0, 3'd3, 32'h0);
    check("edge bits 0,1", avs_readdata, 32'h3);
    bus(1'b0, 1'b1, 3'd3, 32'h3);
    check("irq same cycle as clear", {31'd0, irq}, 32'd1);
    cyc(1);
    check("irq after clear", {31'd0, irq}, 32'd0);
    bus(1'b1, 1'b0, 3'd3, 32'h0);
    check("edge after clear", avs_readdata, 32'h0);

    // falling edge ignored in rising mode, then set/clear collision
    in_export = 4'h2;
    cyc(20);
    check("irq on fall", {31'd0, irq}, 32'd0);
    in_export = 4'h3;
    cyc(18);
    bus(1'b0, 1'b1, 3'd3, 32'h1);
    cyc(1);
    check("irq after collision", {31'd0, irq}, 32'd1);
    bus(1'b1, 1'b0, 3'd3, 32'h0);
    check("edge after collision", avs_readdata, 32'h1);

    // reset part way through a debounce
    in_export = 4'h0;
    bus(1'b0, 1'b1, 3'd1, 32'h155);
    in_export = 4'h1;
    cyc(10);
    do_reset(2);
    check("midreset out_export", {14'd0, out_export}, 32'h0002_AAAA);
    check("midreset irq", {31'd0, irq}, 32'd0);
    check("midreset readdata", avs_readdata, 32'd0);
    measure_deb("midreset debounce latency", 18);

    // randomized run against the model
    in_export = 4'h0;
    do_reset(2);
    model_reset();
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst, r_rd, r_wr;
      logic [2:0]  r_a;
      logic [31:0] r_d;
      logic [3:0]  r_in;
      r_in = in_export;
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          r_in[i] = ~r_in[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : $urandom_range(17, 40);
        end
      end
      r_rst = ($urandom_range(0, 599) == 0);
      r_rd  = ($urandom_range(0, 2) == 0);
      r_wr  = ($urandom_range(0, 3) == 0);
      r_a   = 3'($urandom_range(0, 7));
      r_d   = $urandom;
      in_export = r_in; reset_reset = r_rst;
      avs_read = r_rd; avs_write = r_wr; avs_address = r_a; avs_writedata = r_d;
      @(negedge clk_clk);
      model_step(r_rst, r_in, r_rd, r_wr, r_a, r_d);
      check("rand readdata", avs_readdata, m_rdata);
      check("rand irq", {31'd0, irq}, {31'd0, m_irq});
      check("rand out_export", {14'd0, out_export}, {14'd0, m_out});
    end
    reset_reset = 1'b0; avs_read = 1'b0; avs_write = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_edge_irq.md
Name: pio_edge_irq

Overview:
Parametrised Avalon-MM general-purpose I/O peripheral. It is the successor to the fixed-width key, switch, LED and hex PIOs in the Nios II system.
- Input channels are synchronised and debounced, and edges are captured per channel into a sticky register.
- Edge capture is maskable to a level interrupt.
- The output register supports atomic set and clear.
- One instance replaces each key/switch/LED PIO; IN_WIDTH and OUT_WIDTH are chosen per instance.

Parameters:
IN_WIDTH, 4, number of input channels (1..32)
OUT_WIDTH, 18, number of output bits (1..32)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced value changes; 0 = bypass (debounced = synchronised)
EDGE_TYPE, 0, capture mode for all channels: 0 rising, 1 falling, 2 any edge
OUT_RESET, 0, reset value of the output register (low OUT_WIDTH bits used)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  reset, synchronous, active-high
avs_address  in  3  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, valid the cycle after avs_read
in_export  in  IN_WIDTH  asynchronous inputs (keys/switches)
out_export  out  OUT_WIDTH  output register (LEDs/hex)
irq  out  1  level interrupt, active-high

Behaviour:
- One clock, clk_clk. Reset is synchronous and active-high on reset_reset. All state updates on the rising edge of clk_clk.
- Reset values:
  - out_export = OUT_RESET; avs_readdata = 0.
  - Synchroniser flops = 0; debounced = 0; debounce counters = 0.
  - EDGE = 0; MASK = 0; irq = 0.
- Reset mid-operation: all state returns to the reset values. A debounce or capture in progress is discarded.
- Synchroniser: two flops per channel. sync = in_export delayed 2 cycles.
- Debounce, per channel:
  - Counter is width ceil(log2(DEBOUNCE_CYCLES+1)).
  - If sync == deb, the counter clears.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES: deb <= sync, counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes deb.
  - Total latency from an in_export change to deb = 2 + DEBOUNCE_CYCLES cycles (2 when bypassed).
- Edge detect: deb_q = deb delayed 1 cycle.
  - rise = deb & ~deb_q; fall = ~deb & deb_q.
  - Selected edge per EDGE_TYPE. The selected edge sets EDGE[i] one cycle after deb changes.
  - A high input after reset yields a rising edge. Software clears EDGE after init.
- Register map (word address, 32-bit data, unused bits read 0, writes to RO ignored):
  - 0 DATA_IN, RO: debounced inputs.
  - 1 DATA_OUT, RW: output register.
  - 2 IRQ_MASK, RW: low IN_WIDTH bits.
  - 3 EDGE_CAPTURE, R/W1C: sticky edge flags.
  - 4 OUT_SET, WO: out |= wdata.
  - 5 OUT_CLR, WO: out &= ~wdata.
  - 6 PARAMS, RO: [5:0] = IN_WIDTH, [13:8] = OUT_WIDTH, [17:16] = EDGE_TYPE.
  - 7: reads 0, writes ignored.
- Reads:
  - Fixed read latency 1. avs_readdata is registered and holds its value until the next read.
  - A read returns the register state before any same-cycle write.
- Simultaneous events:
  - An edge arriving in the same cycle as a W1C of the same EDGE bit: set wins, bit stays 1.
  - avs_read and avs_write asserted together: both are performed.
- irq = |(EDGE & MASK), registered. It asserts 1 cycle after the EDGE bit or MASK bit becomes set, and deasserts 1 cycle after clear.
- out_export is driven directly from the output register. It updates the cycle after the write.

Test Plan:
- Reset: assert reset_reset 2 cycles with OUT_RESET=18'h2AAAA -> out_export=18'h2AAAA, irq=0, reads of addr 0/2/3 return 0, addr 6 returns 32'h0000_1204 for IN_WIDTH=4, OUT_WIDTH=18, EDGE_TYPE=0.
- Debounce: DEBOUNCE_CYCLES=16; toggle in_export[0] high for 10 cycles then low -> DATA_IN stays 0. Hold high -> DATA_IN[0]=1 exactly 18 cycles after the input rise.
- Edge capture and IRQ: MASK=4'h1, EDGE_TYPE=0, stable rise on in_export[0] -> EDGE=4'h1, irq=1 one cycle later. A rise on in_export[1] sets EDGE[1] with irq unchanged. Write 4'h3 to addr 3 -> EDGE=0, irq=0 the following cycle.
- Set/clear collision: W1C of EDGE[0] issued in the same cycle an edge sets EDGE[0] -> EDGE[0] reads 1, irq stays 1.
- Output set/clear: write 18'h00F0F to addr 1, 18'h30000 to addr 4, 18'h0000F to addr 5 -> out_export=18'h30F00, and a read of addr 1 returns 32'h0003_0F00.
- Reset mid-debounce: input high, reset asserted at counter=8 -> after release DATA_IN=0 and the counter restarts. DATA_IN=1 arrives 18 cycles after the synchroniser refills.
